// File: rtl/fifo_pop_router_if.sv
// fifo_pop_router_if
//   Bundles every non-clock signal of fifo_pop_router so the router and its
//   environment connect through one port.
//
//   Source side : src_empty, src_valid, src_data in; src_read out.
//   Dest side   : d0/d1 almost_full and full in; d0/d1 write and data out.
//   Threshold   : init, th_almost_*_in in; th_fifos_almost_* out.
//   Status      : state, idle, error out.
//
//   Modports
//     master : the environment (source FIFO, destination FIFOs, controller).
//     slave  : the router itself.
interface fifo_pop_router_if #(
  parameter int unsigned DATA_SIZE       = 12,
  parameter int unsigned MAIN_QUEUE_SIZE = 3
);
  logic                       init;
  logic [MAIN_QUEUE_SIZE-1:0] th_almost_full_in;
  logic [MAIN_QUEUE_SIZE-1:0] th_almost_empty_in;
  logic                       src_empty;
  logic                       src_valid;
  logic [DATA_SIZE-1:0]       src_data;
  logic                       d0_almost_full;
  logic                       d1_almost_full;
  logic                       d0_full;
  logic                       d1_full;
  logic                       src_read;
  logic                       d0_write;
  logic                       d1_write;
  logic [DATA_SIZE-1:0]       d0_data;
  logic [DATA_SIZE-1:0]       d1_data;
  logic [MAIN_QUEUE_SIZE-1:0] th_fifos_almost_full;
  logic [MAIN_QUEUE_SIZE-1:0] th_fifos_almost_empty;
  logic [3:0]                 state;
  logic                       idle;
  logic                       error;

  modport master (
    output init, th_almost_full_in, th_almost_empty_in,
    output src_empty, src_valid, src_data,
    output d0_almost_full, d1_almost_full, d0_full, d1_full,
    input  src_read, d0_write, d1_write, d0_data, d1_data,
    input  th_fifos_almost_full, th_fifos_almost_empty,
    input  state, idle, error
  );

  modport slave (
    input  init, th_almost_full_in, th_almost_empty_in,
    input  src_empty, src_valid, src_data,
    input  d0_almost_full, d1_almost_full, d0_full, d1_full,
    output src_read, d0_write, d1_write, d0_data, d1_data,
    output th_fifos_almost_full, th_fifos_almost_empty,
    output state, idle, error
  );
endinterface

// File: rtl/fifo_pop_router.sv
// fifo_pop_router
//   Pops words from a source FIFO and pushes each one into destination D0 or
//   D1, chosen by bit DEST_BIT of the word. Also latches the almost-full /
//   almost-empty thresholds shared by all FIFOs while in INIT.
//
//   Ports
//     clk     : rising-edge clock
//     reset_L : asynchronous active-low reset
//     bus     : fifo_pop_router_if.slave
//               in  : init, th_almost_*_in, src_empty, src_valid, src_data,
//                     d0/d1 almost_full, d0/d1 full
//               out : src_read (combinational), d0/d1 write + data,
//                     th_fifos_almost_*, state (one-hot), idle, error (sticky)
//
//   Pipeline: src_read in cycle N -> src_valid in N+1 -> dK_write in N+2.
//   A word arriving at a full destination is dropped and raises error, which
//   blocks further reads until reset.
module fifo_pop_router #(
  parameter int unsigned DATA_SIZE       = 12,
  parameter int unsigned MAIN_QUEUE_SIZE = 3,
  parameter int unsigned DEST_BIT        = 11
) (
  input logic               clk,
  input logic               reset_L,
  fifo_pop_router_if.slave  bus
);

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  logic [3:0]                 r_state;
  logic [3:0]                 w_state_d;
  logic                       r_inflight;
  logic [MAIN_QUEUE_SIZE-1:0] r_th_af;
  logic [MAIN_QUEUE_SIZE-1:0] r_th_ae;
  logic                       r_d0_write;
  logic                       r_d1_write;
  logic [DATA_SIZE-1:0]       r_d0_data;
  logic [DATA_SIZE-1:0]       r_d1_data;
  logic                       r_error;

  logic                       w_src_read;
  logic                       w_take;
  logic                       w_dest;
  logic                       w_dest_full;

  // ---------------------------------------------------------------------------
  // Next-state logic; init overrides everything else.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_RESET:  w_state_d = ST_INIT;
      ST_INIT: begin
        if (!bus.init) w_state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.init)            w_state_d = ST_INIT;
        else if (!bus.src_empty) w_state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (bus.init)                          w_state_d = ST_INIT;
        else if (bus.src_empty && !r_inflight) w_state_d = ST_IDLE;
      end
      default:   w_state_d = ST_RESET;
    endcase
  end

  // Pop whenever there is data, room downstream and no outstanding overflow.
  // Both almost_full flags gate the read because the destination of the next
  // word is unknown until it has been popped.
  always_comb begin
    w_src_read = (r_state == ST_ACTIVE) && !bus.init && !bus.src_empty &&
                 !bus.d0_almost_full && !bus.d1_almost_full && !r_error;
  end

  // Words are forwarded whenever src_valid is seen, independent of state, so
  // an in-flight word survives init or backpressure. The RESET state is the
  // one exception: a valid lingering across reset release is discarded.
  always_comb begin
    w_take      = bus.src_valid && (r_state != ST_RESET);
    w_dest      = bus.src_data[DEST_BIT];
    w_dest_full = w_dest ? bus.d1_full : bus.d0_full;
  end

  // ---------------------------------------------------------------------------
  // State, in-flight tracking and thresholds
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= ST_RESET;
      r_inflight <= 1'b0;
      r_th_af    <= '0;
      r_th_ae    <= '0;
    end else begin
      r_state    <= w_state_d;
      r_inflight <= w_src_read;
      if (r_state == ST_INIT) begin
        r_th_af <= bus.th_almost_full_in;
        r_th_ae <= bus.th_almost_empty_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Destination push path and sticky overflow flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_d0_write <= 1'b0;
      r_d1_write <= 1'b0;
      r_d0_data  <= '0;
      r_d1_data  <= '0;
      r_error    <= 1'b0;
    end else begin
      r_d0_write <= 1'b0;
      r_d1_write <= 1'b0;
      if (w_take) begin
        if (w_dest_full) begin
          r_error <= 1'b1;
        end else if (w_dest) begin
          r_d1_write <= 1'b1;
          r_d1_data  <= bus.src_data;
        end else begin
          r_d0_write <= 1'b1;
          r_d0_data  <= bus.src_data;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.src_read              = w_src_read;
    bus.d0_write              = r_d0_write;
    bus.d1_write              = r_d1_write;
    bus.d0_data               = r_d0_data;
    bus.d1_data               = r_d1_data;
    bus.th_fifos_almost_full  = r_th_af;
    bus.th_fifos_almost_empty = r_th_ae;
    bus.state                 = r_state;
    bus.idle                  = (r_state == ST_IDLE);
    bus.error                 = r_error;
  end

endmodule

// File: tb/tb_fifo_pop_router.sv
// Directed bench for fifo_pop_router with a source-FIFO model and a write
// scoreboard carrying destination, data and due cycle for every popped word.
module tb_fifo_pop_router;
  localparam int unsigned DS = 12;
  localparam int unsigned MQ = 3;

  typedef struct {
    logic          dest;
    logic [DS-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  fifo_pop_router_if #(.DATA_SIZE(DS), .MAIN_QUEUE_SIZE(MQ)) bus ();

  fifo_pop_router #(
    .DATA_SIZE      (DS),
    .MAIN_QUEUE_SIZE(MQ),
    .DEST_BIT       (11)
  ) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int wcnt = 0;
  int d0_cnt = 0;
  int d1_cnt = 0;

  logic [DS-1:0] src_q[$];
  exp_t          exp_q[$];
  exp_t          mon_e;

  logic          m_valid;
  logic [DS-1:0] m_data;
  logic          m_empty;
  logic          inj_valid;
  logic [DS-1:0] inj_data;

  // Source FIFO model: registered empty, data valid one cycle after a read.
  assign bus.src_valid = m_valid | inj_valid;
  assign bus.src_data  = inj_valid ? inj_data : m_data;
  assign bus.src_empty = m_empty;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_empty <= 1'b1;
      src_q.delete();
      exp_q.delete();
    end else begin
      if (bus.src_read && src_q.size() > 0) begin
        m_valid <= 1'b1;
        m_data  <= src_q[0];
        exp_q.push_back(exp_t'{src_q[0][11], src_q[0], cyc + 2});
        void'(src_q.pop_front());
      end else begin
        m_valid <= 1'b0;
      end
      m_empty <= (src_q.size() == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every push must match the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (reset_L && (bus.d0_write || bus.d1_write)) begin
      wcnt++;
      if (bus.d0_write) d0_cnt++;
      if (bus.d1_write) d1_cnt++;
      if (exp_q.size() == 0) begin
        check("unexp_wr", {30'd0, bus.d1_write, bus.d0_write}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_dest", {30'd0, bus.d1_write, bus.d0_write}, mon_e.dest ? 32'd2 : 32'd1);
        check("wr_data", mon_e.dest ? bus.d1_data : bus.d0_data, mon_e.data);
        check("wr_lat", cyc, mon_e.due);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && !bus.idle; i++) tick();
    check("wait_idle", bus.idle, 1);
  endtask

  task automatic wait_read(input int max);
    for (int i = 0; i < max && !bus.src_read; i++) tick();
    check("wait_read", bus.src_read, 1);
  endtask

  task automatic do_init(input logic [MQ-1:0] af, input logic [MQ-1:0] ae);
    bus.init = 1'b1;
    bus.th_almost_full_in  = af;
    bus.th_almost_empty_in = ae;
    tick();
    tick();
    bus.init = 1'b0;
    tick();
    check("init_idle", bus.state, 4'b0100);
  endtask

  task automatic check_reset_outputs();
    check("rst_state", bus.state, 4'b0001);
    check("rst_idle", bus.idle, 0);
    check("rst_error", bus.error, 0);
    check("rst_read", bus.src_read, 0);
    check("rst_d0w", bus.d0_write, 0);
    check("rst_d1w", bus.d1_write, 0);
    check("rst_d0d", bus.d0_data, 0);
    check("rst_d1d", bus.d1_data, 0);
    check("rst_thaf", bus.th_fifos_almost_full, 0);
    check("rst_thae", bus.th_fifos_almost_empty, 0);
  endtask

  int w0;

  initial begin
    bus.init = 1'b0;
    bus.th_almost_full_in  = '0;
    bus.th_almost_empty_in = '0;
    bus.d0_almost_full = 1'b0;
    bus.d1_almost_full = 1'b0;
    bus.d0_full = 1'b0;
    bus.d1_full = 1'b0;
    inj_valid = 1'b0;
    inj_data  = '0;
    tick();
    tick();
    check_reset_outputs();

    // Threshold programming
    reset_L = 1'b1;
    bus.init = 1'b1;
    bus.th_almost_full_in  = 3'd5;
    bus.th_almost_empty_in = 3'd1;
    tick();
    check("st_init", bus.state, 4'b0010);
    tick();
    check("th_af", bus.th_fifos_almost_full, 5);
    check("th_ae", bus.th_fifos_almost_empty, 1);
    bus.init = 1'b0;
    tick();
    check("st_idle", bus.state, 4'b0100);
    check("idle", bus.idle, 1);
    bus.th_almost_full_in  = 3'd7;
    bus.th_almost_empty_in = 3'd7;
    tick();
    check("th_af_hold", bus.th_fifos_almost_full, 5);
    check("th_ae_hold", bus.th_fifos_almost_empty, 1);

    // Three back-to-back pops routed by bit 11
    src_q.push_back(12'h005);
    src_q.push_back(12'h803);
    src_q.push_back(12'h00A);
    tick();
    check("still_idle", bus.state, 4'b0100);
    check("rd_idle", bus.src_read, 0);
    tick();
    check("st_active", bus.state, 4'b1000);
    check("rd_1", bus.src_read, 1);
    tick();
    check("rd_2", bus.src_read, 1);
    tick();
    check("rd_3", bus.src_read, 1);
    tick();
    check("rd_stop", bus.src_read, 0);
    wait_idle(10);
    tick();
    check("d0_cnt", d0_cnt, 2);
    check("d1_cnt", d1_cnt, 1);
    check("d0_hold", bus.d0_data, 12'h00A);
    check("d1_hold", bus.d1_data, 12'h803);

    // Backpressure from d1
    bus.d1_almost_full = 1'b1;
    src_q.push_back(12'h011);
    src_q.push_back(12'h822);
    tick();
    tick();
    tick();
    check("bp_state", bus.state, 4'b1000);
    check("bp_read", bus.src_read, 0);
    tick();
    check("bp_read2", bus.src_read, 0);
    bus.d1_almost_full = 1'b0;
    #1;
    check("bp_resume", bus.src_read, 1);
    wait_idle(12);
    tick();
    check("bp_d0_cnt", d0_cnt, 3);
    check("bp_d1_cnt", d1_cnt, 2);

    // Overflow into a full d1
    inj_data  = 12'h800;
    inj_valid = 1'b1;
    bus.d1_full = 1'b1;
    tick();
    inj_valid = 1'b0;
    bus.d1_full = 1'b0;
    check("ovf_error", bus.error, 1);
    check("ovf_d1w", bus.d1_write, 0);
    check("ovf_d1d", bus.d1_data, 12'h822);
    src_q.push_back(12'h033);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("ovf_noread", bus.src_read, 0);
    end
    check("ovf_state", bus.state, 4'b1000);
    check("ovf_sticky", bus.error, 1);
    reset_L = 1'b0;
    #1;
    check("ovf_clr", bus.error, 0);
    tick();
    reset_L = 1'b1;
    do_init(3'd5, 3'd1);

    // Reset while a word is in flight
    src_q.push_back(12'h044);
    wait_read(10);
    tick();
    reset_L = 1'b0;
    #1;
    check_reset_outputs();
    tick();
    tick();
    reset_L = 1'b1;
    w0 = wcnt;
    for (int i = 0; i < 6; i++) tick();
    check("no_wr_after_rst", wcnt, w0);

    // init during ACTIVE with a read in flight
    do_init(3'd3, 3'd2);
    check("th_af2", bus.th_fifos_almost_full, 3);
    check("th_ae2", bus.th_fifos_almost_empty, 2);
    src_q.push_back(12'h055);
    src_q.push_back(12'h866);
    wait_read(10);
    tick();
    bus.init = 1'b1;
    #1;
    check("init_blocks_rd", bus.src_read, 0);
    tick();
    check("init_state", bus.state, 4'b0010);
    check("inflight_d0w", bus.d0_write, 1);
    check("inflight_d0d", bus.d0_data, 12'h055);
    bus.init = 1'b0;
    w0 = d1_cnt;
    for (int i = 0; i < 12 && d1_cnt == w0; i++) tick();
    check("late_d1_cnt", d1_cnt, w0 + 1);
    wait_idle(10);
    check("late_d1d", bus.d1_data, 12'h866);
    check("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_pop_router.md
FIFO_POP_ROUTER -- requirements
Module: fifo_pop_router

Interface
REQ-001 Parameter: DATA_SIZE, 12, width of data words.
REQ-002 Parameter: MAIN_QUEUE_SIZE, 3, width of the threshold fields.
REQ-003 Parameter: DEST_BIT, 11, index of the data bit that selects the destination (0 -> D0, 1 -> D1).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low, with ports named clk and reset_L.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1, clock, rising edge
- reset_L, in, 1, async active-low reset
- init, in, 1, threshold-load request
- th_almost_full_in, in, MAIN_QUEUE_SIZE, almost-full threshold to program
- th_almost_empty_in, in, MAIN_QUEUE_SIZE, almost-empty threshold to program
- src_empty, in, 1, source FIFO empty (registered; updates on the edge that consumes a read)
- src_valid, in, 1, source data valid (one cycle after src_read)
- src_data, in, DATA_SIZE, source FIFO output word
- d0_almost_full / d1_almost_full, in, 1, destination backpressure
- d0_full / d1_full, in, 1, destination full
- src_read, out, 1, pop request to source FIFO
- d0_write / d1_write, out, 1, push strobes
- d0_data / d1_data, out, DATA_SIZE, push data
- th_fifos_almost_full, out, MAIN_QUEUE_SIZE, latched threshold driven to all FIFOs
- th_fifos_almost_empty, out, MAIN_QUEUE_SIZE, latched threshold driven to all FIFOs
- state, out, 4, one-hot FSM state
- idle, out, 1, high in IDLE
- error, out, 1, sticky overflow flag

Function
REQ-006 FSM states SHALL be one-hot: RESET=4'b0001, INIT=4'b0010, IDLE=4'b0100, ACTIVE=4'b1000.
REQ-007 Transitions SHALL be as follows:
- RESET -> INIT on the first edge with reset_L high.
- INIT -> IDLE when init=0.
- IDLE -> INIT when init=1, else IDLE -> ACTIVE when src_empty=0.
- ACTIVE -> INIT when init=1.
- ACTIVE -> IDLE when src_empty=1 and no read is in flight.
- init has priority over every other condition.
REQ-008 In INIT, th_fifos_almost_full and th_fifos_almost_empty SHALL register th_almost_full_in and th_almost_empty_in on every edge; in all other states they SHALL hold their values.
REQ-009 src_read SHALL be combinational and high exactly when all of these hold: state=ACTIVE, init=0, src_empty=0, d0_almost_full=0, d1_almost_full=0, error=0.
REQ-010 A single read SHALL be in flight at most one cycle; back-to-back reads SHALL be allowed (one pop per cycle sustained).
REQ-011 On an edge with src_valid=1, the block SHALL register src_data into dK_data and set dK_write=1 for one cycle, with K=src_data[DEST_BIT].
- The non-selected write strobe SHALL be 0.
- Latency is src_read -> src_valid 1 cycle -> dK_write 1 cycle (2 cycles total).
REQ-012 dK_data SHALL hold its last value when dK_write=0.
REQ-013 An in-flight word SHALL be delivered even if init rises or dK_almost_full rises in the meantime.
REQ-014 If src_valid=1 and the selected dK_full=1 on the same edge:
- the word SHALL be dropped and dK_write SHALL stay 0;
- error SHALL set to 1 and stay set until reset;
- src_read SHALL be held 0 while error=1.
REQ-015 idle SHALL equal (state==IDLE).
REQ-016 src_valid=1 when no read was issued the previous cycle SHALL still be forwarded (the source is trusted).

Reset
REQ-017 While reset_L=0, asynchronously, the block SHALL force:
- state=RESET, idle=0, error=0;
- src_read=0, d0_write=0, d1_write=0;
- d0_data=0, d1_data=0;
- th_fifos_almost_full=0, th_fifos_almost_empty=0.
REQ-018 Reset asserted mid-transfer SHALL discard the in-flight word and SHALL not produce a write after reset_L releases.

Verification
REQ-019 Bench SHALL cover init=1 with th_almost_full_in=3'd5 and th_almost_empty_in=3'd1 for 2 cycles, then init=0: th outputs read 5/1, state INIT -> IDLE, idle=1.
REQ-020 Bench SHALL cover source holding 12'h005, 12'h803, 12'h00A: src_read high 3 consecutive cycles; d0 receives 12'h005 then 12'h00A, d1 receives 12'h803, each 2 cycles after its read; state returns to IDLE.
REQ-021 Bench SHALL cover d1_almost_full=1 with the source non-empty: src_read=0 and state=ACTIVE; d1_almost_full -> 0 resumes reads on the next cycle.
REQ-022 Bench SHALL cover src_valid=1, src_data=12'h800, d1_full=1: d1_write stays 0, error=1, and src_read stays 0 afterwards until reset.
REQ-023 Bench SHALL cover reset_L pulled low the cycle after src_read: all outputs are 0 immediately, and no d0_write/d1_write occurs after release.
REQ-024 Bench SHALL cover init=1 during ACTIVE with a read in flight: the in-flight word is still written, and state goes to INIT.
